// File: rtl/word_serializer.sv
// Parallel-to-serial word transmitter: MSB-first, one bit per strobe, framed by frame_o.
// A one-entry holding register allows the next word to be accepted while the current one shifts.
module word_serializer #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned BIT_PERIOD = 1,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             serial_out,
   output logic             shift_en_o,
   output logic             frame_o,
   output logic             tx_done,
   output logic             busy
);

   localparam int unsigned BW = $clog2(WIDTH) + 1;
   localparam int unsigned DW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] hold_reg_q;
   logic             hold_valid_q;
   logic [WIDTH-1:0] shift_reg_q;
   logic [BW-1:0]    bit_cnt_q;
   logic [DW-1:0]    div_cnt_q;
   logic [GW-1:0]    gap_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         hold_reg_q   <= '0;
         hold_valid_q <= 1'b0;
         shift_reg_q  <= '0;
         bit_cnt_q    <= '0;
         div_cnt_q    <= '0;
         gap_cnt_q    <= '0;
      end else begin
         // Capture needs an empty holder and drain needs a full one, so they never collide.
         if (tx_valid && !hold_valid_q) begin
            hold_reg_q   <= tx_data;
            hold_valid_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (hold_valid_q) begin
                  state_q      <= StShift;
                  shift_reg_q  <= hold_reg_q;
                  hold_valid_q <= 1'b0;
                  bit_cnt_q    <= '0;
                  div_cnt_q    <= '0;
               end
            end
            StShift: begin
               if (div_cnt_q == DIV_LAST) begin
                  shift_reg_q <= {shift_reg_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q   <= bit_cnt_q + BW'(1);
                  div_cnt_q   <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_q   <= StGap;
                     gap_cnt_q <= '0;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DW'(1);
               end
            end
            StGap: begin
               if (gap_cnt_q == GAP_LAST) begin
                  if (hold_valid_q) begin
                     state_q      <= StShift;
                     shift_reg_q  <= hold_reg_q;
                     hold_valid_q <= 1'b0;
                     bit_cnt_q    <= '0;
                     div_cnt_q    <= '0;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs decode registered state only; nothing combinational from tx_valid/tx_data.
   assign tx_ready   = !hold_valid_q;
   assign frame_o    = (state_q == StShift);
   assign serial_out = frame_o && shift_reg_q[WIDTH-1];
   assign shift_en_o = frame_o && (div_cnt_q == DIV_LAST);
   assign tx_done    = (state_q == StGap) && (gap_cnt_q == '0);
   assign busy       = (state_q != StIdle) || hold_valid_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: a BIT_PERIOD=1 instance with a loopback receiver model,
// plus a BIT_PERIOD=3 instance walked cycle by cycle.
module tb_word_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] tx_data, tx_data3;
   logic        tx_valid, tx_valid3;
   logic        tx_ready, serial_out, shift_en_o, frame_o, tx_done, busy;
   logic        tx_ready3, serial3, shift_en3, frame3, tx_done3, busy3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   word_serializer #(.WIDTH(32), .BIT_PERIOD(1), .GAP_CYCLES(1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .serial_out (serial_out),
      .shift_en_o (shift_en_o),
      .frame_o    (frame_o),
      .tx_done    (tx_done),
      .busy       (busy)
   );

   word_serializer #(.WIDTH(32), .BIT_PERIOD(3), .GAP_CYCLES(1)) u_dut3 (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data3),
      .tx_valid   (tx_valid3),
      .tx_ready   (tx_ready3),
      .serial_out (serial3),
      .shift_en_o (shift_en3),
      .frame_o    (frame3),
      .tx_done    (tx_done3),
      .busy       (busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Receiver model: counter clears while frame_o is low, one bit per strobe.
   logic [31:0] rword;
   int          rcnt, strobes, frame_cycles, done_cnt, low_run, last_gap;
   bit          prev_frame, seen_frame;
   logic [31:0] rx_q[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (tx_done) begin
            check("done_after_frame", 32'(prev_frame), 32'd1);
            done_cnt++;
         end
         if (frame_o) begin
            frame_cycles++;
            if (!prev_frame && seen_frame) last_gap = low_run;
            low_run    = 0;
            seen_frame = 1'b1;
         end else begin
            low_run++;
         end
         if (!frame_o) begin
            rcnt = 0;
         end else if (shift_en_o) begin
            rword = {rword[30:0], serial_out};
            rcnt++;
            strobes++;
            if (rcnt == 32) begin
               rx_q.push_back(rword);
               rcnt = 0;
            end
         end
         prev_frame = frame_o;
      end
   end

   task automatic clear_mon();
      @(posedge clk);
      #1;
      rcnt = 0; strobes = 0; frame_cycles = 0; done_cnt = 0;
      low_run = 0; last_gap = -1; seen_frame = 1'b0; prev_frame = 1'b0;
      rx_q.delete();
   endtask

   task automatic send(input logic [31:0] w, input bit sel, input bit keep);
      int n = 0;
      @(negedge clk);
      if (sel) begin tx_data3 = w; tx_valid3 = 1'b1; end
      else     begin tx_data  = w; tx_valid  = 1'b1; end
      while (!(sel ? tx_ready3 : tx_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("send_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      if (!keep) begin
         if (sel) tx_valid3 = 1'b0;
         else     tx_valid  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || tx_valid) && n < 5000);
      if (n >= 5000) check("idle_timeout", 32'(n), 32'd0);
   endtask

   logic [31:0] sent[$];
   logic [31:0] w3, got3;
   int          cnt;

   initial begin
      reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid3 = 1'b0; tx_data3 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_frame", 32'(frame_o), 32'd0);
      check("rst_serial", 32'(serial_out), 32'd0);
      check("rst_shift_en", 32'(shift_en_o), 32'd0);
      check("rst_tx_done", 32'(tx_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Single word, latency and bit order.
      clear_mon();
      send(32'hA5A5F00F, 1'b0, 1'b0);
      check("t1_ready_low", 32'(tx_ready), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_frame_lat0", 32'(frame_o), 32'd0);
      @(negedge clk);
      check("t1_frame_lat1", 32'(frame_o), 32'd1);
      check("t1_msb", 32'(serial_out), 32'd1);
      wait_idle();
      check("t1_words", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("t1_word", rx_q[0], 32'hA5A5F00F);
      check("t1_frame_cycles", 32'(frame_cycles), 32'd32);
      check("t1_strobes", 32'(strobes), 32'd32);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);

      // Back-to-back, second word offered mid-shift.
      clear_mon();
      send(32'hDEADBEEF, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      send(32'h12345678, 1'b0, 1'b0);
      check("t2_ready_low", 32'(tx_ready), 32'd0);
      wait_idle();
      check("t2_words", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         check("t2_word0", rx_q[0], 32'hDEADBEEF);
         check("t2_word1", rx_q[1], 32'h12345678);
      end
      check("t2_strobes", 32'(strobes), 32'd64);
      check("t2_frame_cycles", 32'(frame_cycles), 32'd64);
      check("t2_done_cnt", 32'(done_cnt), 32'd2);
      check("t2_gap", 32'(last_gap), 32'd1);

      // BIT_PERIOD=3 instance, walked cycle by cycle.
      w3 = 32'h80000001;
      got3 = '0;
      send(w3, 1'b1, 1'b0);
      @(negedge clk);
      check("t3_frame_lat0", 32'(frame3), 32'd0);
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         check("t3_frame", 32'(frame3), 32'd1);
         check("t3_strobe", 32'(shift_en3), 32'((i % 3) == 2));
         check("t3_bit", 32'(serial3), 32'(w3[31 - i / 3]));
         if (shift_en3) got3 = {got3[30:0], serial3};
      end
      @(negedge clk);
      check("t3_frame_end", 32'(frame3), 32'd0);
      check("t3_done", 32'(tx_done3), 32'd1);
      check("t3_word", got3, 32'h80000001);

      // Reset after 10th strobe with a second word held.
      clear_mon();
      send(32'hFFFFFFFF, 1'b0, 1'b0);
      tx_data = 32'h55555555;
      tx_valid = 1'b1;
      cnt = 0;
      for (int n = 0; n < 100 && cnt < 10; n++) begin
         @(negedge clk);
         if (shift_en_o) cnt++;
         if (tx_valid && !tx_ready && cnt > 0) tx_valid = 1'b0;
      end
      check("t4_strobes", 32'(cnt), 32'd10);
      check("t4_held", 32'(tx_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("t4_frame", 32'(frame_o), 32'd0);
      check("t4_serial", 32'(serial_out), 32'd0);
      check("t4_ready", 32'(tx_ready), 32'd1);
      check("t4_done", 32'(tx_done), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      clear_mon();
      repeat (80) @(negedge clk);
      check("t4_no_frame", 32'(frame_cycles), 32'd0);
      check("t4_no_words", 32'(rx_q.size()), 32'd0);
      check("t4_no_done", 32'(done_cnt), 32'd0);

      // tx_valid held high, new word each transfer.
      clear_mon();
      sent.delete();
      sent.push_back(32'h0000_0001);
      sent.push_back(32'hFFFF_0000);
      sent.push_back(32'h8000_8000);
      sent.push_back(32'h1357_9BDF);
      for (int i = 0; i < 4; i++) send(sent[i], 1'b0, (i < 3));
      wait_idle();
      check("t5_words", 32'(rx_q.size()), 32'd4);
      check("t5_done_cnt", 32'(done_cnt), 32'd4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++) check("t5_word", rx_q[i], sent[i]);

      // Loopback with 100 random words.
      clear_mon();
      sent.delete();
      for (int i = 0; i < 100; i++) begin
         sent.push_back($urandom);
         send(sent[i], 1'b0, 1'b0);
      end
      wait_idle();
      check("t6_words", 32'(rx_q.size()), 32'd100);
      check("t6_done_cnt", 32'(done_cnt), 32'd100);
      for (int i = 0; i < 100 && i < rx_q.size(); i++) check("t6_word", rx_q[i], sent[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
